// File: rtl/spi_cmd_if.sv
// Bus request channel between the SPI command decoder (master) and the
// system bus arbiter (slave).
interface spi_cmd_if #(
  parameter int ADDR_WIDTH = 17
);
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [7:0]            bus_wr_data;
  logic                  bus_ack;
  logic [7:0]            bus_rd_data;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wr_data,
    input  bus_ack, bus_rd_data
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wr_data,
    output bus_ack, bus_rd_data
  );
endinterface

// File: rtl/spi_cmd.sv
// SPI command decoder: decodes one command per CS-low frame from the SPI byte
// buffer and issues a single read or write on the system bus.
module spi_cmd #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       spi_cs_n,
  input  logic [2:0] rx_count,
  input  logic [7:0] rx0,
  input  logic [7:0] rx1,
  input  logic [7:0] rx2,
  input  logic [7:0] rx3,
  spi_cmd_if.master  bus,
  output logic [7:0] tx_byte,
  output logic       spi_ready,
  output logic [1:0] dbg_state_o
);

  // Handshake: bus_req rises with we/addr/wr_data valid and holds them stable
  // until the one-cycle bus_ack pulse; bus_rd_data is sampled on that edge.

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_WRITE_AT   = 3'b100;
  localparam logic [2:0] OP_READ_AT    = 3'b110;
  localparam logic [2:0] OP_WRITE_NEXT = 3'b101;
  localparam logic [2:0] OP_READ_NEXT  = 3'b111;

  logic                  cs_meta_q, cs_s_q;
  logic [1:0]            state_q, state_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
  logic [7:0]            bus_wr_data_q, bus_wr_data_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic [ADDR_WIDTH-1:0] addr_reg_q, addr_reg_d;

  logic [2:0]            cmd_len;
  logic                  cmd_valid;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [7:0]            cmd_data;
  logic                  match;
  logic                  unused_cmd_bits;

  assign unused_cmd_bits = ^rx0[4:1];

  always_comb begin
    cmd_len   = 3'd1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = ADDR_WIDTH'({rx0[0], rx1, rx2});
    cmd_data  = 8'h00;
    case (rx0[7:5])
      OP_WRITE_AT: begin
        cmd_len   = 3'd4;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_data  = rx3;
      end
      OP_READ_AT: begin
        cmd_len   = 3'd3;
        cmd_valid = 1'b1;
      end
      OP_WRITE_NEXT: begin
        cmd_len   = 3'd2;
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = addr_reg_q + ADDR_WIDTH'(1);
        cmd_data  = rx1;
      end
      OP_READ_NEXT: begin
        cmd_valid = 1'b1;
        cmd_addr  = addr_reg_q + ADDR_WIDTH'(1);
      end
      default: ;
    endcase
  end

  // Fires only on the exact count, so bytes past the command are ignored.
  assign match = !cs_s_q && (rx_count != 3'd0) && (rx_count == cmd_len);

  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    tx_byte_d     = tx_byte_q;
    addr_reg_d    = addr_reg_q;
    case (state_q)
      ST_IDLE: begin
        if (match) begin
          if (cmd_valid) begin
            state_d       = ST_REQ;
            bus_req_d     = 1'b1;
            bus_we_d      = cmd_we;
            bus_addr_d    = cmd_addr;
            bus_wr_data_d = cmd_data;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_REQ: begin
        if (bus.bus_ack) begin
          state_d    = ST_DONE;
          bus_req_d  = 1'b0;
          addr_reg_d = bus_addr_q;
          if (!bus_we_q) tx_byte_d = bus.bus_rd_data;
        end
      end
      ST_DONE: begin
        if (cs_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      cs_meta_q     <= 1'b1;
      cs_s_q        <= 1'b1;
      state_q       <= ST_IDLE;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_wr_data_q <= 8'h00;
      tx_byte_q     <= 8'h00;
      addr_reg_q    <= '1;
    end else begin
      cs_meta_q     <= spi_cs_n;
      cs_s_q        <= cs_meta_q;
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      tx_byte_q     <= tx_byte_d;
      addr_reg_q    <= addr_reg_d;
    end
  end

  assign bus.bus_req     = bus_req_q;
  assign bus.bus_we      = bus_we_q;
  assign bus.bus_addr    = bus_addr_q;
  assign bus.bus_wr_data = bus_wr_data_q;
  assign tx_byte         = tx_byte_q;
  assign spi_ready       = (state_q == ST_IDLE);
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_spi_cmd.sv
// Directed bench for spi_cmd: drives SPI frames through the byte-buffer
// inputs and acts as the bus arbiter.
module tb_spi_cmd;

  logic       sys_clk;
  logic       reset;
  logic       spi_cs_n;
  logic [2:0] rx_count;
  logic [7:0] rx0, rx1, rx2, rx3;
  logic [7:0] tx_byte;
  logic       spi_ready;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // {we, addr[16:0], wr_data[7:0]}
  logic [25:0] exp_q[$];

  spi_cmd_if #(.ADDR_WIDTH(17)) bus ();

  spi_cmd #(.ADDR_WIDTH(17)) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .spi_cs_n    (spi_cs_n),
    .rx_count    (rx_count),
    .rx0         (rx0),
    .rx1         (rx1),
    .rx2         (rx2),
    .rx3         (rx3),
    .bus         (bus),
    .tx_byte     (tx_byte),
    .spi_ready   (spi_ready),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},     32'(bus.bus_req), 32'h0);
    check_eq({tag, "_we"},      32'(bus.bus_we), 32'h0);
    check_eq({tag, "_addr"},    32'(bus.bus_addr), 32'h0);
    check_eq({tag, "_wr_data"}, 32'(bus.bus_wr_data), 32'h0);
    check_eq({tag, "_tx_byte"}, 32'(tx_byte), 32'h0);
    check_eq({tag, "_ready"},   32'(spi_ready), 32'h1);
  endtask

  // driver tasks
  task automatic frame_begin();
    spi_cs_n = 1'b0;
    rx_count = 3'd0;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic frame_end();
    spi_cs_n = 1'b1;
    rx_count = 3'd0;
    repeat (4) @(negedge sys_clk);
    check_eq("ready_after_cs", 32'(spi_ready), 32'h1);
  endtask

  task automatic load(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3, input int n);
    rx0 = b0; rx1 = b1; rx2 = b2; rx3 = b3;
    for (int i = 1; i <= n; i++) begin
      rx_count = 3'(i);
      @(negedge sys_clk);
    end
  endtask

  task automatic expect_txn(input logic we, input logic [16:0] addr, input logic [7:0] data);
    exp_q.push_back({we, addr, data});
  endtask

  task automatic wait_req(input int max_cycles);
    int n = 0;
    while (!bus.bus_req && n < max_cycles) begin
      @(negedge sys_clk);
      n++;
    end
    check_eq("req_seen", 32'(bus.bus_req), 32'h1);
  endtask

  // scoreboard: compare the live request against the oldest expected one
  task automatic check_txn();
    logic [25:0] e;
    if (exp_q.size() == 0) begin
      check_eq("txn_expected", 32'(exp_q.size()), 32'h1);
    end else begin
      e = exp_q.pop_front();
      check_eq("txn_we",   32'(bus.bus_we), 32'(e[25]));
      check_eq("txn_addr", 32'(bus.bus_addr), 32'(e[24:8]));
      if (e[25]) check_eq("txn_wr_data", 32'(bus.bus_wr_data), 32'(e[7:0]));
    end
  endtask

  task automatic ack(input int wait_cycles, input logic [7:0] rd);
    for (int i = 0; i < wait_cycles; i++) begin
      check_eq("req_hold", 32'(bus.bus_req), 32'h1);
      @(negedge sys_clk);
    end
    bus.bus_ack     = 1'b1;
    bus.bus_rd_data = rd;
    @(negedge sys_clk);
    bus.bus_ack     = 1'b0;
    bus.bus_rd_data = 8'h00;
    check_eq("req_drop", 32'(bus.bus_req), 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    spi_cs_n = 1'b1;
    rx_count = 3'd0;
    rx0 = 8'h00; rx1 = 8'h00; rx2 = 8'h00; rx3 = 8'h00;
    bus.bus_ack = 1'b0;
    bus.bus_rd_data = 8'h00;
    #1;
    check_reset_outputs("rst");
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);

    // READ_NEXT straight after reset targets address 0
    frame_begin();
    expect_txn(1'b0, 17'h00000, 8'h00);
    load(8'hE0, 8'h00, 8'h00, 8'h00, 1);
    wait_req(4);
    check_txn();
    ack(1, 8'h11);
    check_eq("tx_rn0", 32'(tx_byte), 32'h11);
    frame_end();

    // WRITE_AT with exact one-cycle request latency and 3-cycle ack
    frame_begin();
    expect_txn(1'b1, 17'h11234, 8'h5A);
    load(8'h81, 8'h12, 8'h34, 8'h5A, 3);
    check_eq("wa_req_early", 32'(bus.bus_req), 32'h0);
    rx_count = 3'd4;
    @(negedge sys_clk);
    check_eq("wa_req_latency", 32'(bus.bus_req), 32'h1);
    check_eq("wa_ready_busy", 32'(spi_ready), 32'h0);
    check_txn();
    ack(3, 8'hEE);
    check_eq("wa_addr_stable", 32'(bus.bus_addr), 32'h11234);
    check_eq("wa_tx_kept", 32'(tx_byte), 32'h11);
    check_eq("wa_ready_done", 32'(spi_ready), 32'h0);
    frame_end();

    // READ_AT then READ_NEXT (zero-wait ack)
    frame_begin();
    expect_txn(1'b0, 17'h08000, 8'h00);
    load(8'hC0, 8'h80, 8'h00, 8'h00, 3);
    wait_req(4);
    check_txn();
    ack(2, 8'hA5);
    check_eq("ra_tx", 32'(tx_byte), 32'hA5);
    frame_end();

    frame_begin();
    expect_txn(1'b0, 17'h08001, 8'h00);
    load(8'hE0, 8'h00, 8'h00, 8'h00, 1);
    wait_req(4);
    check_txn();
    ack(0, 8'h3C);
    check_eq("rn_tx", 32'(tx_byte), 32'h3C);
    frame_end();

    // WRITE_NEXT wraps from 17'h1FFFF to 0
    frame_begin();
    expect_txn(1'b1, 17'h1FFFF, 8'h11);
    load(8'h81, 8'hFF, 8'hFF, 8'h11, 4);
    wait_req(4);
    check_txn();
    ack(1, 8'h00);
    frame_end();
    frame_begin();
    expect_txn(1'b1, 17'h00000, 8'h77);
    load(8'hA0, 8'h77, 8'h00, 8'h00, 2);
    wait_req(4);
    check_txn();
    ack(1, 8'h00);
    check_eq("wn_tx_kept", 32'(tx_byte), 32'h3C);
    frame_end();

    // aborted WRITE_AT after 3 bytes, then a normal frame
    frame_begin();
    load(8'h81, 8'h12, 8'h34, 8'h5A, 3);
    spi_cs_n = 1'b1;
    rx_count = 3'd0;
    repeat (5) @(negedge sys_clk);
    check_eq("abort_no_req", 32'(bus.bus_req), 32'h0);
    check_eq("abort_ready", 32'(spi_ready), 32'h1);
    frame_begin();
    expect_txn(1'b1, 17'h0ABCD, 8'hEF);
    load(8'h80, 8'hAB, 8'hCD, 8'hEF, 4);
    wait_req(4);
    check_txn();
    ack(1, 8'h00);
    frame_end();

    // invalid opcode, spurious ack in IDLE, then READ_NEXT from kept addr_reg
    frame_begin();
    load(8'h20, 8'h00, 8'h00, 8'h00, 1);
    check_eq("inv_no_req", 32'(bus.bus_req), 32'h0);
    check_eq("inv_ready", 32'(spi_ready), 32'h0);
    repeat (3) @(negedge sys_clk);
    check_eq("inv_no_req_late", 32'(bus.bus_req), 32'h0);
    check_eq("inv_ready_late", 32'(spi_ready), 32'h0);
    frame_end();
    bus.bus_ack = 1'b1;
    bus.bus_rd_data = 8'h99;
    @(negedge sys_clk);
    bus.bus_ack = 1'b0;
    bus.bus_rd_data = 8'h00;
    @(negedge sys_clk);
    check_eq("spurious_tx", 32'(tx_byte), 32'h3C);
    check_eq("spurious_ready", 32'(spi_ready), 32'h1);
    frame_begin();
    expect_txn(1'b0, 17'h0ABCE, 8'h00);
    load(8'hE0, 8'h00, 8'h00, 8'h00, 1);
    wait_req(4);
    check_txn();
    ack(1, 8'h5C);
    check_eq("rn2_tx", 32'(tx_byte), 32'h5C);
    frame_end();

    // CS rises while in REQ: transaction still completes
    frame_begin();
    expect_txn(1'b0, 17'h10010, 8'h00);
    load(8'hC1, 8'h00, 8'h10, 8'h00, 3);
    wait_req(4);
    check_txn();
    spi_cs_n = 1'b1;
    rx_count = 3'd0;
    repeat (4) @(negedge sys_clk);
    check_eq("csreq_held", 32'(bus.bus_req), 32'h1);
    ack(0, 8'h77);
    check_eq("csreq_done_busy", 32'(spi_ready), 32'h0);
    check_eq("csreq_tx", 32'(tx_byte), 32'h77);
    @(negedge sys_clk);
    check_eq("csreq_idle", 32'(spi_ready), 32'h1);

    // reset mid-REQ, then first frame after reset
    frame_begin();
    expect_txn(1'b1, 17'h00042, 8'h99);
    load(8'h80, 8'h00, 8'h42, 8'h99, 4);
    wait_req(4);
    check_txn();
    reset = 1'b1;
    #1;
    check_reset_outputs("midreq_rst");
    spi_cs_n = 1'b1;
    rx_count = 3'd0;
    @(negedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);
    frame_begin();
    expect_txn(1'b0, 17'h00000, 8'h00);
    load(8'hE0, 8'h00, 8'h00, 8'h00, 1);
    wait_req(4);
    check_txn();
    ack(1, 8'h66);
    check_eq("post_rst_tx", 32'(tx_byte), 32'h66);
    frame_end();

    // final report
    check_eq("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
